score_keeper: RTL



---
 rtl/game_pkg.sv | 16 +
 rtl/bcd_step.sv | 43 ++++
 rtl/score_keeper.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the score path: BCD digit geometry, flash FSM
// encoding and the default flash duration for a 50 MHz system clock.
package game_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned SCORE_W = 2 * BCD_W;

    // 0.25 s at 50 MHz
    localparam logic [23:0] FLASH_CYCLES_50MHZ = 24'd12_500_000;

    typedef enum logic {
        IDLE  = 1'b0,
        FLASH = 1'b1
    } flash_state_t;

endpackage

// File: rtl/bcd_step.sv
// Combinational two-digit BCD +1 / -1 with carry/borrow between digits.
// Results saturate: +1 at MAX_VALUE and -1 at 00 return the input unchanged.
module bcd_step
    import game_pkg::*;
#(
    parameter logic [SCORE_W-1:0] MAX_VALUE = 8'h99
) (
    input  logic [SCORE_W-1:0] value,
    output logic [SCORE_W-1:0] inc_value,
    output logic [SCORE_W-1:0] dec_value,
    output logic               at_max,
    output logic               at_zero
);

    logic [BCD_W-1:0] ones;
    logic [BCD_W-1:0] tens;

    assign ones    = value[BCD_W-1:0];
    assign tens    = value[SCORE_W-1:BCD_W];
    assign at_max  = (value == MAX_VALUE);
    assign at_zero = (value == '0);

    // Digit-wise increment/decrement with saturation at both ends
    always_comb begin
        inc_value = value;
        dec_value = value;
        if (!at_max) begin
            if (ones == BCD_W'(9)) begin
                inc_value = {tens + BCD_W'(1), BCD_W'(0)};
            end else begin
                inc_value = {tens, ones + BCD_W'(1)};
            end
        end
        if (!at_zero) begin
            if (ones == BCD_W'(0)) begin
                dec_value = {tens - BCD_W'(1), BCD_W'(9)};
            end else begin
                dec_value = {tens, ones - BCD_W'(1)};
            end
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Two-digit BCD score register driven by the game controller's up/down/clear
// strobes. Each request is edge-detected so a held level counts once. Every
// real score change restarts a display flash timer; reaching a multiple of
// ten pulses levelUp.
// Optional: define SCORE_KEEPER_HIGHSCORE_EN to add highScore/newHigh tracking.
module score_keeper
    import game_pkg::*;
#(
    parameter logic [SCORE_W-1:0] MAX_SCORE      = 8'h99,
    parameter logic [BCD_W-1:0]   MILESTONE_ONES = 4'h0,
    parameter int unsigned        CNT_W          = 24,
    parameter logic [CNT_W-1:0]   FLASH_CYCLES   = CNT_W'(FLASH_CYCLES_50MHZ)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               scoreUp,
    input  logic               scoreDown,
    input  logic               scoreRst,
    output logic [SCORE_W-1:0] currentScore,
    output logic               atMax,
    output logic               atZero,
    output logic               levelUp,
    output logic               changeFlash,
    output logic               flashDir
`ifdef SCORE_KEEPER_HIGHSCORE_EN
    ,
    output logic [SCORE_W-1:0] highScore,
    output logic               newHigh
`endif
);

    logic               up_q, down_q, clr_q;
    logic               up_ev, down_ev, clr_ev, clear;
    logic               do_inc, do_dec;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] inc_score, dec_score;
    logic               at_max_w, at_zero_w;
    logic               level_q, level_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    flash_state_t       state_q, state_d;

    bcd_step #(
        .MAX_VALUE (MAX_SCORE)
    ) u_bcd_step (
        .value     (score_q),
        .inc_value (inc_score),
        .dec_value (dec_score),
        .at_max    (at_max_w),
        .at_zero   (at_zero_w)
    );

    assign up_ev   = scoreUp & ~up_q;
    assign down_ev = scoreDown & ~down_q;
    assign clr_ev  = scoreRst & ~clr_q;
    // A held clear level wins just like a fresh clear edge
    assign clear   = scoreRst | clr_ev;
    // Coincident up/down edges cancel; saturated steps are silent
    assign do_inc  = up_ev & ~down_ev & ~at_max_w;
    assign do_dec  = down_ev & ~up_ev & ~at_zero_w;

    // Next-state: flash countdown, then score/flash updates in priority order
    always_comb begin
        score_d = score_q;
        level_d = 1'b0;
        dir_d   = dir_q;
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            FLASH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear) begin
            score_d = '0;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (do_inc) begin
            score_d = inc_score;
            dir_d   = 1'b1;
            state_d = FLASH;
            cnt_d   = FLASH_CYCLES - CNT_W'(1);
            level_d = (inc_score[BCD_W-1:0] == MILESTONE_ONES) && (inc_score != '0);
        end else if (do_dec) begin
            score_d = dec_score;
            dir_d   = 1'b0;
            state_d = FLASH;
            cnt_d   = FLASH_CYCLES - CNT_W'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            clr_q   <= 1'b0;
            score_q <= '0;
            level_q <= 1'b0;
            dir_q   <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            up_q    <= scoreUp;
            down_q  <= scoreDown;
            clr_q   <= scoreRst;
            score_q <= score_d;
            level_q <= level_d;
            dir_q   <= dir_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign currentScore = score_q;
    assign atMax        = at_max_w;
    assign atZero       = at_zero_w;
    assign levelUp      = level_q;
    assign changeFlash  = (state_q == FLASH);
    assign flashDir     = dir_q;

`ifdef SCORE_KEEPER_HIGHSCORE_EN
    logic [SCORE_W-1:0] high_q, high_d;
    logic               new_high_q, new_high_d;

    // BCD digits order the same as binary, so a plain compare is enough
    always_comb begin
        high_d     = high_q;
        new_high_d = 1'b0;
        if (score_d > high_q) begin
            high_d     = score_d;
            new_high_d = 1'b1;
        end
    end

    // High score survives scoreRst; only RST clears it
    always_ff @(posedge CLK) begin
        if (RST) begin
            high_q     <= '0;
            new_high_q <= 1'b0;
        end else begin
            high_q     <= high_d;
            new_high_q <= new_high_d;
        end
    end

    assign highScore = high_q;
    assign newHigh   = new_high_q;
`endif

endmodule
